// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo block.
// Pointer and count widths are derived from DEPTH through clog2().
package sync_fifo_pkg;

  // Ceiling log2; usable in parameter and port-width expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Array has no reset so it maps onto block RAM; only the read register resets.
module sdp_ram
  import sync_fifo_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WORD_WIDTH-1:0]     wdata,
  input  logic                      re,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WORD_WIDTH-1:0]     rdata
);

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [WORD_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register holds when re is low, so the consumer can sample late.
  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO feeding uart_tx: registered dout, flags decoded from pointers.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int AF_THRESHOLD = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [WORD_WIDTH-1:0]   din,
  output logic                    full,
  output logic                    almost_full,
  input  logic                    re,
  output logic [WORD_WIDTH-1:0]   dout,
  output logic                    empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  output logic                    overflow,
  output logic                    underflow,
`endif
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wr_ok, rd_ok;

  // Extra MSB distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign wr_ok = we & ~full  & ~rst;
  assign rd_ok = re & ~empty & ~rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign count       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (count >= PW'(AF_THRESHOLD));

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (we & full);
    underflow_d = underflow_q | (re & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  sdp_ram #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (din),
    .re    (rd_ok),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (dout)
  );

endmodule
